// File: rtl/tt_scanner.sv
// Truth-table scanner: steps X_out through 0..15, DWELL cycles per value, capturing Y_in and counting mismatches against EXP.
// Latency: done pulses in the cycle after edge E0+16*DWELL (E0 = edge that accepts start); all outputs registered.
module tt_scanner #(
   parameter int unsigned DWELL = 4,
   parameter logic [63:0] EXP   = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [3:0]  X_out,
   input  logic [3:0]  Y_in,
   output logic        busy,
   output logic        done,
   output logic [63:0] tt,
   output logic [4:0]  err_cnt,
   output logic        err
);

   localparam int unsigned   CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    x_q, x_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [63:0]   tt_q, tt_d;
   logic [4:0]    err_cnt_q, err_cnt_d;
   logic          err_q, err_d;
   logic [3:0]    exp_y;
   logic          sample;

   always_comb begin
      exp_y = '0;
      for (int k = 0; k < 4; k++) begin
         exp_y[k] = EXP[{2'(k), x_q}];
      end
      sample = (state_q == RUN) && (cnt_q == CNT_LAST);

      state_d   = state_q;
      cnt_d     = cnt_q;
      x_d       = x_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      tt_d      = tt_q;
      err_cnt_d = err_cnt_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               tt_d      = '0;
               err_cnt_d = '0;
               x_d       = 4'd0;
               cnt_d     = '0;
               busy_d    = 1'b1;
            end
         end
         RUN: begin
            if (sample) begin
               for (int k = 0; k < 4; k++) begin
                  tt_d[{2'(k), x_q}] = Y_in[k];
               end
               if (Y_in != exp_y) begin
                  err_cnt_d = err_cnt_q + 5'd1;
               end
               cnt_d = '0;
               if (x_q == 4'd15) begin
                  state_d = FIN;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  x_d     = 4'd0;
               end else begin
                  x_d = x_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // err tracks the count that will be registered this edge, so it lines up with err_cnt.
      err_d = (err_cnt_d != 5'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         x_q       <= 4'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         tt_q      <= '0;
         err_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         x_q       <= x_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         tt_q      <= tt_d;
         err_cnt_q <= err_cnt_d;
         err_q     <= err_d;
      end
   end

   assign X_out   = x_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign tt      = tt_q;
   assign err_cnt = err_cnt_q;
   assign err     = err_q;

endmodule

// File: tb/tb_tt_scanner.sv
// Bench for tt_scanner: three instances with different DWELL/EXP share a randomizable 4-in/4-out function.
module tb_tt_scanner;

   localparam logic [63:0] EXP_A = 64'hFF00_F0F0_CCCC_AAAA;
   localparam logic [63:0] EXP_B = 64'h0;
   localparam logic [63:0] EXP_C = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  start_v = 3'b000;
   logic [1:0]  sel = 2'd0;
   logic [63:0] fn = 64'h0;

   logic [3:0]  x_a, x_b, x_c, y_a, y_b, y_c;
   logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
   logic        err_a, err_b, err_c;
   logic [63:0] tt_a, tt_b, tt_c;
   logic [4:0]  ec_a, ec_b, ec_c;

   logic [3:0]  x_m;
   logic        busy_m, done_m, err_m;
   logic [63:0] tt_m;
   logic [4:0]  ec_m;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // The function block under test: Y = fn[4X+3:4X]
   assign y_a = fn[{x_a, 2'b00} +: 4];
   assign y_b = fn[{x_b, 2'b00} +: 4];
   assign y_c = fn[{x_c, 2'b00} +: 4];

   tt_scanner #(.DWELL(4), .EXP(EXP_A)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .X_out(x_a), .Y_in(y_a),
      .busy(busy_a), .done(done_a), .tt(tt_a), .err_cnt(ec_a), .err(err_a));
   tt_scanner #(.DWELL(4), .EXP(EXP_B)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .X_out(x_b), .Y_in(y_b),
      .busy(busy_b), .done(done_b), .tt(tt_b), .err_cnt(ec_b), .err(err_b));
   tt_scanner #(.DWELL(1), .EXP(EXP_C)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .X_out(x_c), .Y_in(y_c),
      .busy(busy_c), .done(done_c), .tt(tt_c), .err_cnt(ec_c), .err(err_c));

   always_comb begin
      case (sel)
         2'd0:    begin x_m = x_a; busy_m = busy_a; done_m = done_a; err_m = err_a; tt_m = tt_a; ec_m = ec_a; end
         2'd1:    begin x_m = x_b; busy_m = busy_b; done_m = done_b; err_m = err_b; tt_m = tt_b; ec_m = ec_b; end
         default: begin x_m = x_c; busy_m = busy_c; done_m = done_c; err_m = err_c; tt_m = tt_c; ec_m = ec_c; end
      endcase
   end

   function automatic logic [63:0] exp_of(input logic [1:0] s);
      return (s == 2'd0) ? EXP_A : (s == 2'd1) ? EXP_B : EXP_C;
   endfunction

   function automatic int dwell_of(input logic [1:0] s);
      return (s == 2'd2) ? 1 : 4;
   endfunction

   // Reference: walk the 16 X values, read Y from the function table, build the tables, count mismatching rows.
   function automatic void model(input logic [63:0] f, input logic [63:0] ev,
                                 output logic [63:0] tt_e, output int errs);
      logic [3:0] y, e;
      logic [5:0] bi;
      tt_e = '0;
      errs = 0;
      for (int x = 0; x < 16; x++) begin
         y = f[6'(4 * x) +: 4];
         for (int k = 0; k < 4; k++) begin
            bi = 6'(16 * k + x);
            tt_e[bi] = y[k];
            e[k] = ev[bi];
         end
         if (y != e) errs++;
      end
   endfunction

   function automatic logic [63:0] identity_fn();
      logic [63:0] f;
      for (int x = 0; x < 16; x++) f[6'(4 * x) +: 4] = 4'(x);
      return f;
   endfunction

   // Pulse start on the selected instance; lat = negedges after the drive until done is seen (-1 on timeout).
   task automatic do_scan(output int lat);
      @(negedge clk);
      start_v[sel] = 1'b1;
      lat = -1;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         start_v = 3'b000;
         if (done_m) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic scan_and_check(input string name);
      int          lat, errs;
      logic [63:0] tt_e;
      model(fn, exp_of(sel), tt_e, errs);
      do_scan(lat);
      checks++;
      if (lat !== 16 * dwell_of(sel) + 1) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, 16 * dwell_of(sel) + 1);
      end
      checks++;
      if (tt_m !== tt_e || ec_m !== 5'(errs) || err_m !== (errs != 0)) begin
         errors++;
         $display("FAIL %s result: tt=%h ec=%0d err=%b want tt=%h ec=%0d err=%b",
                  name, tt_m, ec_m, err_m, tt_e, errs, errs != 0);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (tt_m !== tt_e || ec_m !== 5'(errs) || busy_m !== 1'b0 || done_m !== 1'b0) begin
         errors++;
         $display("FAIL %s idle_hold: tt=%h ec=%0d busy=%b done=%b want tt=%h ec=%0d busy=0 done=0",
                  name, tt_m, ec_m, busy_m, done_m, tt_e, errs);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start_v = 3'b111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({busy_a, busy_b, busy_c, done_a, done_b, done_c, err_a, err_b, err_c} !== 9'd0 ||
             {x_a, x_b, x_c} !== 12'd0 || {tt_a, tt_b, tt_c} !== 192'd0 || {ec_a, ec_b, ec_c} !== 15'd0) begin
            errors++;
            $display("FAIL reset cycle %0d: busy=%b%b%b done=%b%b%b x=%h/%h/%h ec=%0d/%0d/%0d want all 0",
                     i, busy_a, busy_b, busy_c, done_a, done_b, done_c, x_a, x_b, x_c, ec_a, ec_b, ec_c);
         end
      end
      start_v = 3'b000;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy_a, busy_b, busy_c} !== 3'b000) begin
         errors++;
         $display("FAIL reset release: busy=%b%b%b want 000", busy_a, busy_b, busy_c);
      end
   endtask

   task automatic test_identity();
      sel = 2'd0;
      fn = identity_fn();
      scan_and_check("identity");
      checks++;
      if (tt_m !== 64'hFF00_F0F0_CCCC_AAAA || ec_m !== 5'd0 || err_m !== 1'b0) begin
         errors++;
         $display("FAIL identity const: tt=%h ec=%0d err=%b want tt=ff00f0f0ccccaaaa ec=0 err=0", tt_m, ec_m, err_m);
      end
   endtask

   task automatic test_exp_zero();
      sel = 2'd1;
      fn = identity_fn();
      scan_and_check("exp_zero");
      checks++;
      if (tt_m !== 64'hFF00_F0F0_CCCC_AAAA || ec_m !== 5'd15 || err_m !== 1'b1) begin
         errors++;
         $display("FAIL exp_zero const: tt=%h ec=%0d err=%b want tt=ff00f0f0ccccaaaa ec=15 err=1", tt_m, ec_m, err_m);
      end
   endtask

   task automatic test_dwell1();
      sel = 2'd2;
      fn = 64'hFFFF_FFFF_FFFF_FFFF;
      scan_and_check("dwell1");
      checks++;
      if (tt_m !== 64'hFFFF_FFFF_FFFF_FFFF || ec_m !== 5'd0) begin
         errors++;
         $display("FAIL dwell1 const: tt=%h ec=%0d want tt=all ones ec=0", tt_m, ec_m);
      end
   endtask

   task automatic test_random();
      logic [63:0] ev;
      for (int it = 0; it < 8; it++) begin
         sel = 2'($urandom_range(2, 0));
         ev = exp_of(sel);
         if (it[0]) begin
            fn = {$urandom, $urandom};
         end else begin
            // Start from the expected function and corrupt a few rows.
            for (int x = 0; x < 16; x++)
               fn[6'(4 * x) +: 4] = {ev[6'(48 + x)], ev[6'(32 + x)], ev[6'(16 + x)], ev[6'(x)]};
            for (int j = 0; j < int'($urandom_range(3, 0)); j++)
               fn[6'(4 * $urandom_range(15, 0)) +: 4] ^= 4'($urandom_range(15, 1));
         end
         scan_and_check($sformatf("random%0d", it));
      end
   endtask

   task automatic test_midscan();
      int found, bad, dones;
      sel = 2'd0;
      fn = identity_fn();
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      found = 0;
      for (int n = 0; n < 200 && found == 0; n++) begin
         @(negedge clk);
         if (x_m == 4'd7) found = 1;
      end
      start_v[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start_v[0] = 1'b0;
      bad = 0;
      dones = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (busy_m && x_m < 4'd7) bad++;
         if (done_m) dones++;
      end
      checks++;
      if (found != 1 || bad != 0 || dones != 1) begin
         errors++;
         $display("FAIL midscan_start: reached7=%0d restarts=%0d dones=%0d want 1 0 1", found, bad, dones);
      end
      // Reset in the middle of a fresh scan.
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      found = 0;
      for (int n = 0; n < 200 && found == 0; n++) begin
         @(negedge clk);
         if (x_m == 4'd5) found = 1;
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (found != 1 || x_m !== 4'd0 || busy_m !== 1'b0 || tt_m !== 64'd0 || done_m !== 1'b0 || ec_m !== 5'd0) begin
         errors++;
         $display("FAIL reset_abort: reached5=%0d x=%0d busy=%b tt=%h done=%b ec=%0d want 1 0 0 0 0 0",
                  found, x_m, busy_m, tt_m, done_m, ec_m);
      end
      @(negedge clk);
      checks++;
      if (done_m !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort no_done: done=%b want 0", done_m);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int          found, errs;
      logic [63:0] tt_e;
      sel = 2'd0;
      fn = {$urandom, $urandom};
      model(fn, EXP_A, tt_e, errs);
      @(negedge clk);
      start_v[0] = 1'b1;
      for (int rep = 0; rep < 3; rep++) begin
         found = 0;
         for (int n = 0; n < 200 && found == 0; n++) begin
            @(negedge clk);
            if (done_m) found = 1;
         end
         checks++;
         if (found != 1 || tt_m !== tt_e || ec_m !== 5'(errs)) begin
            errors++;
            $display("FAIL b2b scan%0d: done_seen=%0d tt=%h ec=%0d want 1 %h %0d", rep, found, tt_m, ec_m, tt_e, errs);
         end
         if (rep == 2) start_v[0] = 1'b0;
         @(negedge clk);
         checks++;
         if (busy_m !== 1'b0 || done_m !== 1'b0) begin
            errors++;
            $display("FAIL b2b gap%0d: busy=%b done=%b want 0 0", rep, busy_m, done_m);
         end
         @(negedge clk);
         checks++;
         if (rep < 2 && (busy_m !== 1'b1 || tt_m !== 64'd0 || ec_m !== 5'd0 || err_m !== 1'b0)) begin
            errors++;
            $display("FAIL b2b restart%0d: busy=%b tt=%h ec=%0d err=%b want 1 0 0 0", rep, busy_m, tt_m, ec_m, err_m);
         end else if (rep == 2 && (busy_m !== 1'b0 || tt_m !== tt_e)) begin
            errors++;
            $display("FAIL b2b stop: busy=%b tt=%h want 0 %h", busy_m, tt_m, tt_e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_exp_zero();
      test_dwell1();
      test_random();
      test_midscan();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
